// File: rtl/mda_pkg.sv
// Shared types and widths for the MDA video RAM path.
package mda_pkg;

  localparam int unsigned MDA_VRAM_AW = 12;
  localparam int unsigned MDA_RAM_AW  = 19;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_RDATA,
    ARB_HOLD
  } arb_state_e;

endpackage

// File: rtl/mda_bus_sync.sv
// N-flop synchronizer for an active-low ISA strobe; resets to the released level.
module mda_bus_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = (sync_q << 1) | STAGES'(d);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mda_vram_arbiter.sv
// Shares the video SRAM port between ISA CPU cycles and display fetches;
// display fetches always win, CPU cycles use sequencer-granted slots only.
module mda_vram_arbiter
  import mda_pkg::*;
#(
  parameter int unsigned            VRAM_AW     = MDA_VRAM_AW,
  parameter logic [MDA_RAM_AW-1:0]  RAM_BASE    = 19'h00000,
  parameter int unsigned            SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        mem_cs,
  input  logic [14:0] bus_a,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic [7:0]  bus_d,
  output logic [7:0]  bus_dout,
  output logic        bus_dir_mem,
  output logic        bus_rdy,
  input  logic        isa_op_enable,
  input  logic        pix_read,
  input  logic [18:0] pix_addr,
  output logic        pix_valid,
  output logic [18:0] ram_a,
  output logic [7:0]  ram_dq_out,
  input  logic [7:0]  ram_d,
  output logic        ram_we_l
);

  localparam int unsigned RAW = MDA_RAM_AW;

  logic memr_s;
  logic memw_s;

  mda_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_memr (
    .clk   (clk),
    .rst_l (rst_l),
    .d     (bus_memr_l),
    .q     (memr_s)
  );

  mda_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_memw (
    .clk   (clk),
    .rst_l (rst_l),
    .d     (bus_memw_l),
    .q     (memw_s)
  );

  arb_state_e         state_q, state_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         dout_q, dout_d;
  logic               we_q, we_d;
  logic               rdy_q, rdy_d;
  logic               pix_valid_q;
  logic [RAW-1:0]     ram_a_q;
  logic [RAW-1:0]     ram_a_c;

  logic req_c;
  logic strobe_rel_c;
  logic grant_c;
  logic cpu_port_c;
  logic unused_bus_a_c;

  // Upper window bits only select a mirror of the implemented VRAM.
  assign unused_bus_a_c = ^bus_a;

  // Exactly one synced strobe low; both low together is not a valid cycle.
  assign req_c        = mem_cs & (memr_s ^ memw_s);
  assign strobe_rel_c = we_q ? memw_s : memr_s;
  assign grant_c      = isa_op_enable & ~pix_read;
  // A released strobe wins over a same-cycle grant so an aborted cycle never touches SRAM.
  assign cpu_port_c   = (state_q == ARB_WAIT) & grant_c & ~strobe_rel_c;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdy_d   = rdy_q;
    dout_d  = dout_q;
    case (state_q)
      ARB_IDLE: begin
        if (req_c) begin
          addr_d  = bus_a[VRAM_AW-1:0];
          wdata_d = bus_d;
          we_d    = ~memw_s;
          rdy_d   = 1'b0;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (strobe_rel_c) begin
          rdy_d   = 1'b1;
          state_d = ARB_IDLE;
        end else if (grant_c) begin
          if (we_q) begin
            rdy_d   = 1'b1;
            state_d = ARB_HOLD;
          end else begin
            state_d = ARB_RDATA;
          end
        end
      end
      ARB_RDATA: begin
        dout_d  = ram_d;
        rdy_d   = 1'b1;
        state_d = ARB_HOLD;
      end
      ARB_HOLD: begin
        if (strobe_rel_c) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Port mux: display fetch, then CPU grant, else hold the last address.
  always_comb begin
    ram_a_c = ram_a_q;
    if (pix_read) begin
      ram_a_c = pix_addr;
    end else if (cpu_port_c) begin
      ram_a_c = RAM_BASE | RAW'(addr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ARB_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rdy_q       <= 1'b1;
      dout_q      <= '0;
      pix_valid_q <= 1'b0;
      ram_a_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rdy_q       <= rdy_d;
      dout_q      <= dout_d;
      pix_valid_q <= pix_read;
      ram_a_q     <= ram_a_c;
    end
  end

  assign ram_a       = rst_l ? ram_a_c : '0;
  assign ram_we_l    = ~(rst_l & cpu_port_c & we_q);
  assign ram_dq_out  = wdata_q;
  assign bus_dout    = dout_q;
  assign bus_rdy     = rdy_q;
  assign pix_valid   = pix_valid_q;
  assign bus_dir_mem = mem_cs & ~bus_memr_l;

endmodule

// File: tb/tb_mda_vram_arbiter.sv
// Scoreboard bench for mda_vram_arbiter with a behavioural SRAM and shadow memory model.
module tb_mda_vram_arbiter;

  localparam int unsigned SYNC = 2;

  logic        clk;
  logic        rst_l;
  logic        mem_cs;
  logic [14:0] bus_a;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic [7:0]  bus_d;
  logic [7:0]  bus_dout;
  logic        bus_dir_mem;
  logic        bus_rdy;
  logic        isa_op_enable;
  logic        pix_read;
  logic [18:0] pix_addr;
  logic        pix_valid;
  logic [18:0] ram_a;
  logic [7:0]  ram_dq_out;
  logic [7:0]  ram_d;
  logic        ram_we_l;

  mda_vram_arbiter #(
    .VRAM_AW     (12),
    .RAM_BASE    (19'h00000),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .mem_cs        (mem_cs),
    .bus_a         (bus_a),
    .bus_memr_l    (bus_memr_l),
    .bus_memw_l    (bus_memw_l),
    .bus_d         (bus_d),
    .bus_dout      (bus_dout),
    .bus_dir_mem   (bus_dir_mem),
    .bus_rdy       (bus_rdy),
    .isa_op_enable (isa_op_enable),
    .pix_read      (pix_read),
    .pix_addr      (pix_addr),
    .pix_valid     (pix_valid),
    .ram_a         (ram_a),
    .ram_dq_out    (ram_dq_out),
    .ram_d         (ram_d),
    .ram_we_l      (ram_we_l)
  );

  typedef struct {
    int         kind;   // 0 write, 1 read, 2 aborted
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [7:0]  model_mem [4096];
  logic [7:0]  sram [4096];
  int          tests;
  int          fails;
  int          writes_total;
  int          wcnt;
  logic [18:0] wa;
  logic [7:0]  wd;
  logic        prev_rdy;
  logic        prev_pix;
  int unsigned mode;
  int unsigned slot_cnt;
  logic        pre_we;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read SRAM: address in cycle N gives data in cycle N+1.
  always @(posedge clk) begin
    if (pre_we) begin
      sram[pre_a] <= pre_d;
    end else if (!ram_we_l) begin
      sram[ram_a[11:0]] <= ram_dq_out;
    end
    ram_d <= sram[ram_a[11:0]];
  end

  // Sequencer stand-in: slot and display-fetch patterns selected by mode.
  initial begin
    isa_op_enable = 1'b0;
    pix_read      = 1'b0;
    pix_addr      = '0;
    slot_cnt      = 0;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0: begin isa_op_enable = 1'b1; pix_read = 1'b0; end
        1: begin
          isa_op_enable = ($urandom_range(0, 3) == 0);
          pix_read      = ($urandom_range(0, 2) == 0);
          pix_addr      = 19'($urandom);
        end
        2: begin
          isa_op_enable = (slot_cnt == 7);
          slot_cnt      = (slot_cnt + 1) % 8;
          pix_read      = 1'b0;
        end
        3: begin isa_op_enable = 1'b1; pix_read = 1'b1; pix_addr = 19'h00200; end
        default: begin isa_op_enable = 1'b0; pix_read = 1'b0; end
      endcase
    end
  end

  // Monitor: port-level invariants every cycle, scoreboard pop on each bus_rdy rise.
  initial begin
    prev_rdy     = 1'b1;
    prev_pix     = 1'b0;
    wcnt         = 0;
    writes_total = 0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        prev_rdy = 1'b1;
        prev_pix = 1'b0;
        wcnt     = 0;
      end else begin
        if (!ram_we_l) begin
          wcnt++;
          writes_total++;
          wa = ram_a;
          wd = ram_dq_out;
          tests++;
          if (pix_read || !isa_op_enable) begin
            fails++;
            $display("FAIL we_context: pix_read=%0b isa_op_enable=%0b, required 0 and 1",
                     pix_read, isa_op_enable);
          end
        end
        if (pix_read) begin
          tests++;
          if (ram_a !== pix_addr || ram_we_l !== 1'b1) begin
            fails++;
            $display("FAIL pix_mux: ram_a=%h ram_we_l=%b, required %h and 1",
                     ram_a, ram_we_l, pix_addr);
          end
        end
        tests++;
        if (pix_valid !== prev_pix) begin
          fails++;
          $display("FAIL pix_valid: got %b required %b", pix_valid, prev_pix);
        end
        prev_pix = pix_read;
        if (bus_rdy && !prev_rdy) begin
          tests++;
          if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_rdy: bus_rdy rose with no cycle outstanding");
          end else begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
              0: if (wcnt != 1 || wa !== 19'(mon_e.addr) || wd !== mon_e.data) begin
                fails++;
                $display("FAIL cpu_write: writes=%0d a=%h d=%h, required 1 a=%h d=%h",
                         wcnt, wa, wd, 19'(mon_e.addr), mon_e.data);
              end
              1: if (wcnt != 0 || bus_dout !== mon_e.data) begin
                fails++;
                $display("FAIL cpu_read @%h: writes=%0d dout=%h, required 0 dout=%h",
                         mon_e.addr, wcnt, bus_dout, mon_e.data);
              end
              default: if (wcnt != 0) begin
                fails++;
                $display("FAIL abort: writes=%0d required 0", wcnt);
              end
            endcase
          end
          wcnt = 0;
        end
        prev_rdy = bus_rdy;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One ISA memory cycle; the expected completion is queued before the strobe falls.
  task automatic cpu_op(input bit we, input logic [14:0] a, input logic [7:0] d,
                        input bit abort, output int lat);
    exp_t e;
    bit   seen_low;
    bit   done;
    e.kind = abort ? 2 : (we ? 0 : 1);
    e.addr = a[11:0];
    e.data = we ? d : model_mem[a[11:0]];
    if (we && !abort) model_mem[a[11:0]] = d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    mem_cs = 1'b1;
    bus_a  = a;
    bus_d  = d;
    if (we) bus_memw_l = 1'b0;
    else    bus_memr_l = 1'b0;
    #1;
    chk("dir_mem", 32'(bus_dir_mem), 32'(we ? 0 : 1));
    lat      = 0;
    seen_low = 1'b0;
    done     = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus_rdy) begin
        seen_low = 1'b1;
        if (abort) begin
          bus_memr_l = 1'b1;
          bus_memw_l = 1'b1;
          mem_cs     = 1'b0;
        end
      end else if (seen_low) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL rdy_timeout: a=%h we=%0b, bus_rdy never completed the cycle", a, we);
      sb_q.delete();
    end
    bus_memr_l = 1'b1;
    bus_memw_l = 1'b1;
    mem_cs     = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
  endtask

  initial begin
    int          lat;
    int          lowcnt;
    int          wt;
    bit          we;
    logic [7:0]  od;
    tests      = 0;
    fails      = 0;
    mode       = 4;
    rst_l      = 1'b0;
    mem_cs     = 1'b0;
    bus_a      = '0;
    bus_d      = '0;
    bus_memr_l = 1'b1;
    bus_memw_l = 1'b1;
    pre_we     = 1'b0;
    pre_a      = '0;
    pre_d      = '0;

    for (int i = 0; i < 4096; i++) begin
      @(posedge clk);
      #1;
      pre_we       = 1'b1;
      pre_a        = 12'(i);
      pre_d        = 8'(i * 37 + 11);
      model_mem[i] = 8'(i * 37 + 11);
    end
    @(posedge clk);
    #1;
    pre_we = 1'b0;

    chk("rst_bus_rdy",    32'(bus_rdy),    32'h1);
    chk("rst_ram_we_l",   32'(ram_we_l),   32'h1);
    chk("rst_ram_a",      32'(ram_a),      32'h0);
    chk("rst_ram_dq_out", 32'(ram_dq_out), 32'h0);
    chk("rst_bus_dout",   32'(bus_dout),   32'h0);
    chk("rst_pix_valid",  32'(pix_valid),  32'h0);
    chk("rst_dir_mem",    32'(bus_dir_mem), 32'h0);

    rst_l = 1'b1;
    mode  = 0;
    repeat (3) @(posedge clk);

    // Best-case write and mirrored read.
    cpu_op(1'b1, 15'h0123, 8'hA5, 1'b0, lat);
    chk("wr_latency", 32'(lat), 32'(SYNC + 2));
    cpu_op(1'b1, 15'h0123, 8'h3C, 1'b0, lat);
    cpu_op(1'b0, 15'h1123, 8'h00, 1'b0, lat);
    chk("rd_latency", 32'(lat), 32'(SYNC + 3));
    chk("rd_mirror_a", 32'(ram_a), 32'h00123);
    chk("rd_data", 32'(bus_dout), 32'h3C);

    // Display fetches hold off a pending write.
    mode = 3;
    fork
      cpu_op(1'b1, 15'h0456, 8'h5B, 1'b0, lat);
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("prio_wait", 32'(bus_rdy), 32'h0);
        chk("prio_ram_a", 32'(ram_a), 32'h00200);
        mode = 0;
      end
    join
    cpu_op(1'b0, 15'h0456, 8'h00, 1'b0, lat);

    // Sparse CPU slots.
    mode = 2;
    cpu_op(1'b1, 15'h0789, 8'h77, 1'b0, lat);
    cpu_op(1'b0, 15'h0789, 8'h00, 1'b0, lat);
    cpu_op(1'b0, 15'h70AB, 8'h00, 1'b0, lat);

    // Aborted read, then both strobes low together.
    mode = 4;
    cpu_op(1'b0, 15'h0321, 8'h00, 1'b1, lat);
    mode = 0;
    wt     = writes_total;
    lowcnt = 0;
    @(posedge clk);
    #1;
    mem_cs     = 1'b1;
    bus_a      = 15'h0222;
    bus_memr_l = 1'b0;
    bus_memw_l = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!bus_rdy) lowcnt++;
    end
    chk("illegal_rdy", 32'(lowcnt), 32'h0);
    chk("illegal_wr", 32'(writes_total), 32'(wt));
    mem_cs     = 1'b0;
    bus_memr_l = 1'b1;
    bus_memw_l = 1'b1;
    repeat (SYNC + 2) @(posedge clk);

    // Reset while a write is waiting for its slot.
    mode = 4;
    od   = model_mem[12'h555];
    @(posedge clk);
    #1;
    mem_cs     = 1'b1;
    bus_a      = 15'h0555;
    bus_d      = ~od;
    bus_memw_l = 1'b0;
    lowcnt     = 0;
    for (int i = 0; i < 20 && bus_rdy; i++) begin
      @(posedge clk);
      #1;
      lowcnt++;
    end
    chk("rstop_wait", 32'(bus_rdy), 32'h0);
    mode = 0;
    #2;
    chk("rstop_we_pre", 32'(ram_we_l), 32'h0);
    rst_l = 1'b0;
    #1;
    chk("rstop_ram_we_l",   32'(ram_we_l),   32'h1);
    chk("rstop_bus_rdy",    32'(bus_rdy),    32'h1);
    chk("rstop_ram_a",      32'(ram_a),      32'h0);
    chk("rstop_ram_dq_out", 32'(ram_dq_out), 32'h0);
    chk("rstop_bus_dout",   32'(bus_dout),   32'h0);
    chk("rstop_pix_valid",  32'(pix_valid),  32'h0);
    mem_cs     = 1'b0;
    bus_memw_l = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_l = 1'b1;
    repeat (4) @(posedge clk);
    cpu_op(1'b0, 15'h0555, 8'h00, 1'b0, lat);

    // Randomized traffic against random slots and display fetches.
    mode = 1;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      cpu_op(we, 15'($urandom), 8'($urandom), 1'b0, lat);
    end
    mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
